// File: rtl/au_cmp6_arb_pkg.sv
// ---------------------------------------------------------------------------
// au_cmp6_arb_pkg
// Shared constants for the shared-comparator arbiter slice.
//   FLG_*  : bit positions of the six comparison flags inside a flag vector
//   NFLG   : number of flags
//   CNT_W  : width of each per-requester grant counter (stats build only)
//   clog2  : ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package au_cmp6_arb_pkg;

  localparam int FLG_LT = 0;
  localparam int FLG_GT = 1;
  localparam int FLG_EQ = 2;
  localparam int FLG_LE = 3;
  localparam int FLG_GE = 4;
  localparam int FLG_NE = 5;
  localparam int NFLG   = 6;

  localparam int CNT_W  = 16;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/au_cmp6_sgn.sv
// ---------------------------------------------------------------------------
// AU_cmp6_sgn
// Purely combinational signed comparator producing all six relations.
// Parameters:
//   WIDTH : operand width (>= 1), two's complement
//   ARCH  : 0 = direct signed compare
//           1 = sign-bit split plus unsigned magnitude compare
//           2 = sign-bias (flip MSB) then unsigned compare
// Ports:
//   a, b                    in  WIDTH  operands
//   lt, gt, eq, le, ge, ne  out 1      relations of a versus b
// ---------------------------------------------------------------------------
module AU_cmp6_sgn #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             le,
  output logic             ge,
  output logic             ne
);

  logic lt_i;
  logic eq_i;

  // Elaboration-time guard: an illegal configuration stops the build/sim.
  if (WIDTH < 1 || ARCH < 0 || ARCH > 2) begin : g_bad_param
    $fatal(1, "AU_cmp6_sgn: illegal WIDTH=%0d or ARCH=%0d", WIDTH, ARCH);
  end

  assign eq_i = (a == b);

  if (ARCH == 1) begin : g_arch_split
    // Differing signs decide on their own; equal signs compare as unsigned,
    // which is correct for two's complement in both halves of the range.
    assign lt_i = (a[WIDTH-1] & ~b[WIDTH-1]) |
                  ((a[WIDTH-1] == b[WIDTH-1]) & (a < b));
  end else if (ARCH == 2) begin : g_arch_bias
    // Flipping the sign bit maps the signed range monotonically onto the
    // unsigned range, so a plain unsigned compare gives the signed order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    assign lt_i = ((a ^ MSB_MASK) < (b ^ MSB_MASK));
  end else begin : g_arch_direct
    assign lt_i = ($signed(a) < $signed(b));
  end

  assign lt = lt_i;
  assign eq = eq_i;
  assign gt = ~lt_i & ~eq_i;
  assign le = lt_i | eq_i;
  assign ge = ~lt_i;
  assign ne = ~eq_i;

endmodule

// File: rtl/au_rr_pick.sv
// ---------------------------------------------------------------------------
// au_rr_pick
// Combinational round-robin picker: the first asserted request found when
// scanning from ptr upward and wrapping modulo NREQ wins.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IDW   highest-priority index for this cycle (< NREQ)
//   sel  out NREQ  one-hot winner (all zero when no request)
//   idx  out IDW   binary winner index (0 when no request)
// ---------------------------------------------------------------------------
module au_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] sel,
  output logic [IDW-1:0]  idx
);

  logic             found;
  logic [IDW-1:0]   pos;

  // Scan priority order ptr, ptr+1, ... and latch onto the first hit; later
  // hits are masked by found so the result stays one-hot.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        found    = 1'b1;
        sel[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/au_cmp6_sgn_arb.sv
// ---------------------------------------------------------------------------
// au_cmp6_sgn_arb
// Round-robin arbiter sharing one signed six-way comparator among NREQ
// requesters. One requester is granted per cycle; its operands are compared
// combinationally and the flags are registered together with its ID. The
// response side has valid/ready backpressure.
// Parameters:
//   WIDTH (>=1), ARCH (0..2), NREQ (2..8); IDW = max(1, clog2(NREQ)).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req      in  NREQ        level requests, held until granted
//   a_flat   in  NREQ*WIDTH  operand a of requester i at [i*WIDTH +: WIDTH]
//   b_flat   in  NREQ*WIDTH  operand b, same packing
//   gnt      out NREQ        one-hot combinational grant
//   rsp_vld  out 1           response valid
//   rsp_rdy  in  1           response consumer ready
//   rsp_id   out IDW         requester the response belongs to
//   rsp_lt/gt/eq/le/ge/ne    registered flags
// Optional build macro AU_CMP6_SGN_ARB_STATS_EN adds:
//   gnt_cnt_flat out NREQ*16 saturating per-requester grant counters
// ---------------------------------------------------------------------------
module au_cmp6_sgn_arb
  import au_cmp6_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int ARCH  = 0,
  parameter  int NREQ  = 4,
  localparam int IDW   = (clog2(NREQ) > 1) ? clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  input  logic [NREQ*WIDTH-1:0] b_flat,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lt,
  output logic                  rsp_gt,
  output logic                  rsp_eq,
  output logic                  rsp_le,
  output logic                  rsp_ge,
  output logic                  rsp_ne
`ifdef AU_CMP6_SGN_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] gnt_cnt_flat
`endif
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_idx;
  logic [NREQ-1:0]  win_sel;
  logic             accept;
  logic [WIDTH-1:0] a_win;
  logic [WIDTH-1:0] b_win;
  logic [NFLG-1:0]  cmp_flags;
  logic [NFLG-1:0]  rsp_flags;

  // Elaboration-time guard: an illegal configuration stops the build/sim.
  if (WIDTH < 1 || ARCH < 0 || ARCH > 2 || NREQ < 2 || NREQ > 8) begin : g_bad_param
    $fatal(1, "au_cmp6_sgn_arb: illegal WIDTH=%0d ARCH=%0d NREQ=%0d",
           WIDTH, ARCH, NREQ);
  end

  au_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (win_sel),
    .idx (win_idx)
  );

  // A slot opens when the output register is empty or being drained this
  // cycle; reset suppresses any grant so nothing is consumed while clearing.
  assign accept = ~rst & (|req) & (~rsp_vld | rsp_rdy);
  assign gnt    = accept ? win_sel : '0;

  assign a_win = a_flat[int'(win_idx)*WIDTH +: WIDTH];
  assign b_win = b_flat[int'(win_idx)*WIDTH +: WIDTH];

  AU_cmp6_sgn #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_cmp (
    .a  (a_win),
    .b  (b_win),
    .lt (cmp_flags[FLG_LT]),
    .gt (cmp_flags[FLG_GT]),
    .eq (cmp_flags[FLG_EQ]),
    .le (cmp_flags[FLG_LE]),
    .ge (cmp_flags[FLG_GE]),
    .ne (cmp_flags[FLG_NE])
  );

  // Response register and round-robin pointer. An accept overwrites the
  // response in place (no bubble when draining and accepting together);
  // a drain with nothing to accept only drops valid and leaves the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_vld   <= 1'b0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else if (accept) begin
      ptr       <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
      rsp_vld   <= 1'b1;
      rsp_id    <= win_idx;
      rsp_flags <= cmp_flags;
    end else if (rsp_vld && rsp_rdy) begin
      rsp_vld   <= 1'b0;
    end
  end

  assign rsp_lt = rsp_flags[FLG_LT];
  assign rsp_gt = rsp_flags[FLG_GT];
  assign rsp_eq = rsp_flags[FLG_EQ];
  assign rsp_le = rsp_flags[FLG_LE];
  assign rsp_ge = rsp_flags[FLG_GE];
  assign rsp_ne = rsp_flags[FLG_NE];

`ifdef AU_CMP6_SGN_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // Per-requester grant counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (accept && (win_idx == IDW'(i)) && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign gnt_cnt_flat[i*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_au_cmp6_sgn_arb.sv
// ---------------------------------------------------------------------------
// tb_au_cmp6_sgn_arb
// Bench for au_cmp6_sgn_arb: a WIDTH=8/NREQ=4 instance driven by a vector
// table, hand sequences and random traffic checked against a cycle model,
// plus a WIDTH=1/NREQ=2 instance for the single-bit signed corner.
// Defining AU_CMP6_SGN_ARB_STATS_EN also exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_au_cmp6_sgn_arb;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic           rsp_rdy;
  logic [N-1:0]   gnt;
  logic           rsp_vld;
  logic [1:0]     rsp_id;
  logic           rsp_lt, rsp_gt, rsp_eq, rsp_le, rsp_ge, rsp_ne;

  logic [1:0]     req1;
  logic [1:0]     a1_flat;
  logic [1:0]     b1_flat;
  logic           rdy1;
  logic [1:0]     gnt1;
  logic           vld1;
  logic [0:0]     id1;
  logic           lt1, gt1, eq1, le1, ge1, ne1;

`ifdef AU_CMP6_SGN_ARB_STATS_EN
  logic [N*16-1:0] gnt_cnt_flat;
  logic [2*16-1:0] gnt_cnt1_flat;
`endif

  au_cmp6_sgn_arb #(.WIDTH(W), .ARCH(1), .NREQ(N)) dut (
    .clk (clk), .rst (rst), .req (req), .a_flat (a_flat), .b_flat (b_flat),
    .gnt (gnt), .rsp_vld (rsp_vld), .rsp_rdy (rsp_rdy), .rsp_id (rsp_id),
    .rsp_lt (rsp_lt), .rsp_gt (rsp_gt), .rsp_eq (rsp_eq),
    .rsp_le (rsp_le), .rsp_ge (rsp_ge), .rsp_ne (rsp_ne)
`ifdef AU_CMP6_SGN_ARB_STATS_EN
    , .gnt_cnt_flat (gnt_cnt_flat)
`endif
  );

  au_cmp6_sgn_arb #(.WIDTH(1), .ARCH(2), .NREQ(2)) dut1 (
    .clk (clk), .rst (rst), .req (req1), .a_flat (a1_flat), .b_flat (b1_flat),
    .gnt (gnt1), .rsp_vld (vld1), .rsp_rdy (rdy1), .rsp_id (id1),
    .rsp_lt (lt1), .rsp_gt (gt1), .rsp_eq (eq1),
    .rsp_le (le1), .rsp_ge (ge1), .rsp_ne (ne1)
`ifdef AU_CMP6_SGN_ARB_STATS_EN
    , .gnt_cnt_flat (gnt_cnt1_flat)
`endif
  );

  wire [5:0] dut_flags  = {rsp_ne, rsp_ge, rsp_le, rsp_eq, rsp_gt, rsp_lt};
  wire [5:0] dut1_flags = {ne1, ge1, le1, eq1, gt1, lt1};

  // Flag vectors are written {ne, ge, le, eq, gt, lt}.
  localparam logic [5:0] F_LT = 6'b101001;
  localparam logic [5:0] F_GT = 6'b110010;
  localparam logic [5:0] F_EQ = 6'b011100;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the response register contents and the priority index
  // are kept as plain integers and updated from the arbitration rules.
  int         m_ptr;
  bit         m_vld;
  int         m_id;
  logic [5:0] m_flags;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic           rdy;
    logic [N-1:0]   gnt;
    logic           vld;
    logic [1:0]     id;
    logic [5:0]     flags;
    logic           chk_rsp;
  } vec_t;

  vec_t tbl[14];

  function automatic int sext(input logic [W-1:0] v);
    if (v[W-1]) return int'(v) - (1 << W);
    return int'(v);
  endfunction

  function automatic logic [5:0] refFlags(input int sa, input int sb);
    bit lt, gt, eq;
    lt = sa < sb;
    gt = sa > sb;
    eq = sa == sb;
    return {!eq, gt || eq, lt || eq, eq, gt, lt};
  endfunction

  function automatic int refWinner();
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] refGnt();
    int w;
    if (rst) return '0;
    w = refWinner();
    if (w < 0 || (m_vld && !rsp_rdy)) return '0;
    return N'(1 << w);
  endfunction

  task automatic modelStep();
    int w;
    w = refWinner();
    if (rst) begin
      m_ptr = 0; m_vld = 0; m_id = 0; m_flags = '0;
    end else if (w >= 0 && (!m_vld || rsp_rdy)) begin
      m_ptr   = (w + 1) % N;
      m_id    = w;
      m_vld   = 1;
      m_flags = refFlags(sext(a_flat[w*W +: W]), sext(b_flat[w*W +: W]));
    end else if (m_vld && rsp_rdy) begin
      m_vld = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                               input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                               input logic rdy);
    rst = r; req = rq; a_flat = a; b_flat = b; rsp_rdy = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] eg,
                             input logic ev, input logic [1:0] eid,
                             input logic [5:0] ef, input logic crsp);
    check($sformatf("%s.gnt", tag), 32'(gnt), 32'(eg));
    check($sformatf("%s.vld", tag), 32'(rsp_vld), 32'(ev));
    if (crsp) begin
      check($sformatf("%s.id", tag), 32'(rsp_id), 32'(eid));
      check($sformatf("%s.flags", tag), 32'(dut_flags), 32'(ef));
    end
  endtask

  // Close out a cycle: advance the model with the inputs that the DUT will
  // sample at the coming edge, then move to just after that edge.
  task automatic endCycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table rows: {req, a_flat, b_flat, rdy, gnt, vld, id, flags, chk_rsp}
    tbl[0]  = '{4'b0001, 32'h0000_0080, 32'h0000_007F, 1'b1, 4'b0001, 1'b0, 2'd0, 6'b0, 1'b0};
    tbl[1]  = '{4'b0010, 32'h0000_FF00, 32'h0000_FF00, 1'b1, 4'b0010, 1'b1, 2'd0, F_LT, 1'b1};
    tbl[2]  = '{4'b0010, 32'h0000_0100, 32'h0000_FF00, 1'b1, 4'b0010, 1'b1, 2'd1, F_EQ, 1'b1};
    tbl[3]  = '{4'b1111, 32'h0,         32'h0,         1'b1, 4'b0100, 1'b1, 2'd1, F_GT, 1'b1};
    tbl[4]  = '{4'b1111, 32'h0,         32'h0,         1'b1, 4'b1000, 1'b1, 2'd2, F_EQ, 1'b1};
    tbl[5]  = '{4'b1111, 32'h0,         32'h0,         1'b1, 4'b0001, 1'b1, 2'd3, F_EQ, 1'b1};
    tbl[6]  = '{4'b1111, 32'h0,         32'h0,         1'b1, 4'b0010, 1'b1, 2'd0, F_EQ, 1'b1};
    tbl[7]  = '{4'b1111, 32'h0,         32'h0,         1'b1, 4'b0100, 1'b1, 2'd1, F_EQ, 1'b1};
    tbl[8]  = '{4'b0110, 32'h0,         32'h0,         1'b0, 4'b0000, 1'b1, 2'd2, F_EQ, 1'b1};
    tbl[9]  = '{4'b0110, 32'h0,         32'h0,         1'b0, 4'b0000, 1'b1, 2'd2, F_EQ, 1'b1};
    tbl[10] = '{4'b0110, 32'h0,         32'h0,         1'b0, 4'b0000, 1'b1, 2'd2, F_EQ, 1'b1};
    tbl[11] = '{4'b0110, 32'h0,         32'h0,         1'b1, 4'b0010, 1'b1, 2'd2, F_EQ, 1'b1};
    tbl[12] = '{4'b0000, 32'h0,         32'h0,         1'b1, 4'b0000, 1'b1, 2'd1, F_EQ, 1'b1};
    tbl[13] = '{4'b0000, 32'h0,         32'h0,         1'b1, 4'b0000, 1'b0, 2'd0, 6'b0, 1'b0};

    req1 = '0; a1_flat = '0; b1_flat = '0; rdy1 = 1'b1;
    m_ptr = 0; m_vld = 0; m_id = 0; m_flags = '0;

    // Reset, with all requests up during the second cycle: no grant allowed.
    applyStimulus(1'b1, 4'b0000, '0, '0, 1'b1);
    @(negedge clk);
    endCycle();
    applyStimulus(1'b1, 4'b1111, '0, '0, 1'b1);
    req1 = 2'b11;
    @(negedge clk);
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.gnt1", 32'(gnt1), 32'h0);
    endCycle();

    // Post-reset state, plus the single-bit signed instance (1 means -1).
    applyStimulus(1'b0, 4'b0000, '0, '0, 1'b1);
    req1 = 2'b01; a1_flat = 2'b01; b1_flat = 2'b00;
    @(negedge clk);
    checkOutput("reset", 4'b0000, 1'b0, 2'd0, 6'b0, 1'b1);
    check("w1.gnt0", 32'(gnt1), 32'h1);
    endCycle();
    a1_flat = 2'b00; b1_flat = 2'b01;
    @(negedge clk);
    check("w1.vld", 32'(vld1), 32'h1);
    check("w1.id", 32'(id1), 32'h0);
    check("w1.lt", 32'(dut1_flags), 32'(F_LT));
    check("w1.gnt1", 32'(gnt1), 32'h1);
    endCycle();
    req1 = 2'b00;
    @(negedge clk);
    check("w1.gt", 32'(dut1_flags), 32'(F_GT));
    endCycle();

    // Directed table: compare, rotation, backpressure and drain.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].rdy);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].vld,
                  tbl[i].id, tbl[i].flags, tbl[i].chk_rsp);
      endCycle();
    end

    // Reset while a response is stalled: it is discarded, and the pointer
    // returns to 0 so requester 3 is still found by the wrap-around scan.
    applyStimulus(1'b0, 4'b0001, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mid0", 4'b0001, 1'b0, 2'd0, 6'b0, 1'b0);
    endCycle();
    applyStimulus(1'b1, 4'b1000, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mid1", 4'b0000, 1'b1, 2'd0, F_EQ, 1'b1);
    endCycle();
    applyStimulus(1'b0, 4'b1000, 32'h7F00_0000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    checkOutput("mid2", 4'b1000, 1'b0, 2'd0, 6'b0, 1'b0);
    endCycle();
    applyStimulus(1'b0, 4'b0000, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("mid3", 4'b0000, 1'b1, 2'd3, F_GT, 1'b1);
    endCycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(49, 0) == 0) ? 1'b1 : 1'b0, N'($urandom),
                    $urandom, $urandom,
                    ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0);
      if ($urandom_range(3, 0) == 0) b_flat = a_flat;
      @(negedge clk);
      checkOutput("rand", refGnt(), m_vld, 2'(m_id), m_flags, m_vld);
      endCycle();
    end

`ifdef AU_CMP6_SGN_ARB_STATS_EN
    applyStimulus(1'b1, 4'b0000, '0, '0, 1'b1);
    @(negedge clk);
    endCycle();
    applyStimulus(1'b0, 4'b0001, '0, '0, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      endCycle();
    end
    applyStimulus(1'b0, 4'b0000, '0, '0, 1'b1);
    @(negedge clk);
    check("cnt0.sat", 32'(gnt_cnt_flat[15:0]), 32'hFFFF);
    check("cnt1.zero", 32'(gnt_cnt_flat[31:16]), 32'h0);
    endCycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
